// File: rtl/seven_segment_decoder.sv
// rtl/seven_segment_decoder.sv - two-digit seven-segment pattern decoder with input debounce
// Captures tens/ones patterns, waits for them to hold steady, then reports 0..31 or an error.
module seven_segment_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] tens_digit,
  input  logic [6:0] ones_digit,
  input  logic       sample_valid,
  output logic [4:0] number,
  output logic       number_valid,
  input  logic       number_ready,
  output logic       error,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SETTLE, DECODE, OUTPUT} state_t;

  localparam logic [3:0] LAST_COUNT = 4'(STABLE_CYCLES - 1);

  state_t     state;
  logic [3:0] count;
  logic [6:0] tens_cap;
  logic [6:0] ones_cap;

  logic [4:0] tens_dec;
  logic [4:0] ones_dec;
  logic [6:0] sum;
  logic       decode_ok;
  logic       inputs_match;

  // Returns {legal, value}; segment order is a..g from bit 6 down to bit 0.
  function automatic logic [4:0] seg_decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: return 5'b1_0000;
      7'b0110000: return 5'b1_0001;
      7'b1101101: return 5'b1_0010;
      7'b1111001: return 5'b1_0011;
      7'b0110011: return 5'b1_0100;
      7'b1011011: return 5'b1_0101;
      7'b1011111: return 5'b1_0110;
      7'b1110000: return 5'b1_0111;
      7'b1111111: return 5'b1_1000;
      7'b1111011: return 5'b1_1001;
      default:    return 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    // A dark tens digit is a leading blank, i.e. zero; a dark ones digit is not.
    tens_dec     = (tens_cap == 7'b0000000) ? 5'b1_0000 : seg_decode(tens_cap);
    ones_dec     = seg_decode(ones_cap);
    sum          = ({3'b000, tens_dec[3:0]} * 7'd10) + {3'b000, ones_dec[3:0]};
    decode_ok    = tens_dec[4] && ones_dec[4] && (sum <= 7'd31);
    inputs_match = (tens_digit == tens_cap) && (ones_digit == ones_cap);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= 4'd0;
      tens_cap     <= 7'd0;
      ones_cap     <= 7'd0;
      number       <= 5'd0;
      number_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_valid) begin
            tens_cap <= tens_digit;
            ones_cap <= ones_digit;
            count    <= 4'd0;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (!sample_valid) begin
            state <= IDLE;
          end else if (inputs_match) begin
            if (count == LAST_COUNT) begin
              state <= DECODE;
            end else begin
              count <= count + 4'd1;
            end
          end else begin
            tens_cap <= tens_digit;
            ones_cap <= ones_digit;
            count    <= 4'd0;
          end
        end
        DECODE: begin
          number       <= decode_ok ? sum[4:0] : 5'd0;
          error        <= !decode_ok;
          number_valid <= 1'b1;
          state        <= OUTPUT;
        end
        OUTPUT: begin
          if (number_ready) begin
            number_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb/tb_seven_segment_decoder.sv - directed self-checking bench for seven_segment_decoder
// Inputs change and outputs are sampled on the falling clock edge.
module tb_seven_segment_decoder;

  localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001,
                         S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000,
                         S8 = 7'b1111111, S9 = 7'b1111011, SB = 7'b0000000;

  logic       clk;
  logic       reset;
  logic [6:0] tens_digit;
  logic [6:0] ones_digit;
  logic       sample_valid;
  logic [4:0] number;
  logic       number_valid;
  logic       number_ready;
  logic       error;
  logic       busy;

  int tests;
  int fails;

  seven_segment_decoder #(.STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .tens_digit   (tens_digit),
    .ones_digit   (ones_digit),
    .sample_valid (sample_valid),
    .number       (number),
    .number_valid (number_valid),
    .number_ready (number_ready),
    .error        (error),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns the index of the edge after which number_valid was first seen high,
  // counting the capture edge as edge 0; 99 when the bound expires.
  task automatic wait_valid(output int edge_idx, input int first_edge);
    int n;
    n = first_edge;
    edge_idx = 99;
    while (n < first_edge + 30) begin
      @(negedge clk);
      if (number_valid) begin
        edge_idx = n;
        break;
      end
      n++;
    end
  endtask

  // Full transaction with constant inputs and number_ready already high.
  task automatic run_vec(input logic [6:0] t, input logic [6:0] o,
                         input logic [4:0] exp_num, input logic exp_err, input string tag);
    int e;
    tens_digit   = t;
    ones_digit   = o;
    sample_valid = 1'b1;
    number_ready = 1'b1;
    wait_valid(e, 0);
    check({tag, "_latency"}, e, 5);
    check({tag, "_number"}, number, exp_num);
    check({tag, "_error"}, error, exp_err);
    sample_valid = 1'b0;
    @(negedge clk);
    check({tag, "_pulse"}, number_valid, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int e;
    int seen;
    tests = 0;
    fails = 0;
    reset        = 1'b1;
    tens_digit   = 7'd0;
    ones_digit   = 7'd0;
    sample_valid = 1'b0;
    number_ready = 1'b0;
    @(negedge clk);
    check("reset_number", number, 0);
    check("reset_valid", number_valid, 0);
    check("reset_error", error, 0);
    check("reset_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);

    run_vec(S1, S3, 5'd13, 1'b0, "v13");
    run_vec(SB, S7, 5'd7,  1'b0, "v07");
    run_vec(S3, S1, 5'd31, 1'b0, "v31");
    run_vec(S3, S2, 5'd0,  1'b1, "v32");
    run_vec(S1, 7'b0000001, 5'd0, 1'b1, "bad_ones");
    run_vec(S1, SB, 5'd0,  1'b1, "blank_ones");
    run_vec(S2, S9, 5'd29, 1'b0, "v29");
    run_vec(S4, S0, 5'd0,  1'b1, "v40");
    run_vec(S3, S0, 5'd30, 1'b0, "v30");
    run_vec(S0, S8, 5'd8,  1'b0, "v08");
    run_vec(7'b1000000, S1, 5'd0, 1'b1, "bad_tens");
    run_vec(SB, S6, 5'd6,  1'b0, "v06");
    run_vec(S2, S5, 5'd25, 1'b0, "v25");

    // Ones digit changes on SETTLE edge 2: stability count restarts.
    tens_digit   = S1;
    ones_digit   = S3;
    sample_valid = 1'b1;
    number_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ones_digit = S4;
    wait_valid(e, 2);
    check("restart_latency", e, 7);
    check("restart_number", number, 14);
    check("restart_error", error, 0);
    sample_valid = 1'b0;
    @(negedge clk);
    check("restart_pulse", number_valid, 0);

    // Backpressure: result held while inputs toggle; no capture on the handshake edge.
    tens_digit   = S2;
    ones_digit   = S1;
    sample_valid = 1'b1;
    number_ready = 1'b0;
    wait_valid(e, 0);
    check("hold_latency", e, 5);
    for (int i = 0; i < 3; i++) begin
      tens_digit   = (i % 2 == 0) ? S8 : S4;
      ones_digit   = (i % 2 == 0) ? S9 : 7'b0101010;
      sample_valid = (i != 1);
      @(negedge clk);
      check("hold_valid", number_valid, 1);
      check("hold_number", number, 21);
      check("hold_error", error, 0);
    end
    tens_digit   = S1;
    ones_digit   = S1;
    sample_valid = 1'b1;
    number_ready = 1'b1;
    @(negedge clk);
    check("handshake_valid", number_valid, 0);
    check("handshake_busy", busy, 0);
    @(negedge clk);
    check("capture_after_handshake", busy, 1);
    sample_valid = 1'b0;
    @(negedge clk);
    check("settle_abort_busy", busy, 0);
    check("settle_abort_valid", number_valid, 0);

    // Asynchronous reset mid-SETTLE.
    sample_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_settle_busy", busy, 0);
    check("rst_settle_valid", number_valid, 0);
    check("rst_settle_number", number, 0);
    sample_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Asynchronous reset with a result pending in OUTPUT.
    tens_digit   = S1;
    ones_digit   = S9;
    sample_valid = 1'b1;
    number_ready = 1'b0;
    wait_valid(e, 0);
    check("pend_latency", e, 5);
    check("pend_number", number, 19);
    sample_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("rst_out_valid", number_valid, 0);
    check("rst_out_number", number, 0);
    check("rst_out_error", error, 0);
    check("rst_out_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    number_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (number_valid || busy) seen++;
    end
    check("post_reset_quiet", seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seven_segment_decoder.md
SEVEN_SEGMENT_DECODER -- requirements
Module: seven_segment_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the number of consecutive stable sampled cycles required before a decode (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port tens_digit, input, 7 bits: tens segment pattern, bit6=a down to bit0=g, active-high.
REQ-005 SHALL have port ones_digit, input, 7 bits: ones segment pattern, same encoding as tens_digit.
REQ-006 SHALL have port sample_valid, input, 1 bit: the segment inputs carry a pattern to decode.
REQ-007 SHALL have port number, output, 5 bits: the decoded value 0..31.
REQ-008 SHALL have port number_valid, output, 1 bit: number and error are valid.
REQ-009 SHALL have port number_ready, input, 1 bit: the consumer accepts the result.
REQ-010 SHALL have port error, output, 1 bit: the captured pattern was illegal.
REQ-011 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL decode digit patterns as: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011; any other pattern is illegal.
REQ-013 SHALL accept a blank tens pattern (0000000) as tens value 0; a blank ones pattern is illegal.
REQ-014 SHALL use a four-state FSM: IDLE, SETTLE, DECODE, OUTPUT.
REQ-015 SHALL, in IDLE with sample_valid=1 at an edge, capture both patterns, clear the stability counter to 0, and move to SETTLE.
REQ-016 SHALL, in SETTLE with sample_valid=1 and inputs equal to the captured patterns, move to DECODE if the counter equals STABLE_CYCLES-1, otherwise increment the counter.
REQ-017 SHALL, in SETTLE with sample_valid=1 and inputs differing from the captured patterns, recapture the inputs, clear the counter and stay in SETTLE.
REQ-018 SHALL, in SETTLE with sample_valid=0, return to IDLE without producing a result.
REQ-019 SHALL, in DECODE, register number = 10*tens + ones and error=0, then move to OUTPUT.
REQ-020 SHALL, in DECODE with either digit illegal, tens > 3, or tens = 3 with ones > 1, register number=0 and error=1; number_valid is still asserted.
REQ-021 SHALL assert number_valid only in OUTPUT, holding number and error constant until number_valid and number_ready are both 1 at an edge, then return to IDLE.
REQ-022 SHALL ignore tens_digit, ones_digit and sample_valid in DECODE and OUTPUT.
REQ-023 SHALL accept number_ready asserted before number_valid, so the handshake completes on the first OUTPUT edge (a one-cycle number_valid pulse).
REQ-024 SHALL, with constant inputs, assert number_valid after edge STABLE_CYCLES+1, counting the IDLE capture edge as edge 0.
REQ-025 SHALL not start a new capture in the IDLE cycle entered on a handshake edge until the next edge.

Reset
REQ-026 SHALL, while reset=1 and independent of clk, force state to IDLE, counter to 0, captured patterns to 0, and number, number_valid, error to 0 (busy therefore 0).
REQ-027 SHALL discard any in-progress capture or pending result on reset; no number_valid follows release unless a new capture occurs.

Verification
REQ-028 Tens=0110000, ones=1111001 held with sample_valid=1, STABLE_CYCLES=4, number_ready=1 -> number=01101 (13), error=0, number_valid high for exactly one cycle after edge 5.
REQ-029 Tens=0000000, ones=1110000 -> number=7, error=0; tens=1111001, ones=0110000 -> number=31, error=0.
REQ-030 Tens=1111001, ones=1101101 (32), or ones=0000001 -> number=0, error=1, number_valid=1.
REQ-031 Ones changed from "3" to "4" on SETTLE edge 2 -> counter restarts, result is the new value, number_valid after edge 2+STABLE_CYCLES+1.
REQ-032 number_ready low for 3 cycles in OUTPUT while inputs toggle -> number_valid, number and error held constant; transfer on the first edge with number_ready=1, then busy=0.
REQ-033 reset pulsed mid-SETTLE (asynchronous to clk) -> outputs 0 immediately, busy=0; no number_valid after release with sample_valid=0.
